// File: rtl/optical_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : optical_link_pkg
// Description : Frame-format constants and the deframer state type shared by
//               frame_assembly and frame_disassembly on the optical audio link.
// Revision    : 1.0 - initial release
// ============================================================================
package optical_link_pkg;

   localparam logic [7:0] SYNC_WORD  = 8'hE8;
   localparam int         SYNC_BITS  = 8;
   localparam int         DATA_BITS  = 20;
   localparam int         GUARD_BITS = 3;
   localparam int         FRAME_BITS = 32;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_PARITY  = 2'd2,
      ST_GUARD   = 2'd3
   } deframe_state_t;

   // Even parity over a sample word: the transmitted parity bit equals this.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
      return ^word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_disassembly_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module      : bit_sampler
// Description : Synchronises the raw optical line, detects transitions and
//               runs the oversampling phase counter that produces one strobe
//               per line bit at mid-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sampler #(
   parameter int OVERSAMPLE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic bit_strobe,
   output logic bit_val
);

   localparam int            PW  = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0] MID = PW'(OVERSAMPLE / 2);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q,  prev_d;
   logic [PW-1:0] phase_q, phase_d;
   logic          line_edge_w;

   // Next-state: two-stage synchroniser, edge history, and a phase counter
   // that re-aligns on every transition (edge cycle counts as phase 0).
   always_comb begin
      sync1_d     = din;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      line_edge_w = sync2_q ^ prev_q;
      // OVERSAMPLE is a power of two, so the natural overflow is the wrap.
      phase_d     = line_edge_w ? PW'(1) : phase_q + PW'(1);
   end

   // Register the synchroniser chain and phase counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         phase_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         phase_q <= phase_d;
      end
   end

   // A transition in the strobe cycle means the bit boundary moved, so the
   // sample is skipped and the phase re-aligns instead.
   assign bit_strobe = (phase_q == MID) && !line_edge_w;
   assign bit_val    = sync2_q;

endmodule
`default_nettype wire

// File: rtl/frame_disassembly.sv
`default_nettype none
// ============================================================================
// Module      : frame_disassembly
// Description : Receive-side deframer. Hunts for the sync word in the
//               recovered bit stream, extracts the 20-bit sample, checks
//               parity and guard bits, and tracks link lock.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_disassembly
   import optical_link_pkg::*;
#(
   parameter int OVERSAMPLE   = 8,
   parameter int LOCK_FRAMES  = 3,
   parameter int TIMEOUT_BITS = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   output logic [DATA_BITS-1:0] dout,
   output logic                 data_valid,
   output logic                 frame_error,
   output logic                 locked
);

   localparam int               CNT_W      = $clog2(DATA_BITS);
   localparam int               GOOD_W     = $clog2(LOCK_FRAMES + 1);
   localparam int               TO_W       = $clog2(TIMEOUT_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_GUARD = CNT_W'(GUARD_BITS - 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);
   localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_BITS);

   logic bit_strobe_w;
   logic bit_val_w;

   bit_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_sampler (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .bit_strobe (bit_strobe_w),
      .bit_val    (bit_val_w)
   );

   deframe_state_t          state_q,       state_d;
   logic [SYNC_BITS-1:0]    window_q,      window_d;
   logic [DATA_BITS-1:0]    data_q,        data_d;
   logic                    parity_q,      parity_d;
   logic [GUARD_BITS-1:0]   guard_q,       guard_d;
   logic [CNT_W-1:0]        cnt_q,         cnt_d;
   logic [GOOD_W-1:0]       good_q,        good_d;
   logic [TO_W-1:0]         timeout_q,     timeout_d;
   logic [DATA_BITS-1:0]    dout_q,        dout_d;
   logic                    data_valid_q,  data_valid_d;
   logic                    frame_error_q, frame_error_d;
   logic                    locked_q,      locked_d;

   logic [SYNC_BITS-1:0]    window_shift_w;
   logic [GUARD_BITS-1:0]   guard_shift_w;
   logic                    frame_ok_w;
   logic [TO_W-1:0]         timeout_inc_w;
   logic [GOOD_W-1:0]       good_inc_w;

   // Shifted views, frame verdict and saturating increments used below.
   always_comb begin
      window_shift_w = {window_q[SYNC_BITS-2:0], bit_val_w};
      guard_shift_w  = {guard_q[GUARD_BITS-2:0], bit_val_w};
      frame_ok_w     = (parity_q == even_parity(data_q)) && (guard_shift_w == '0);
      timeout_inc_w  = (timeout_q == TO_MAX) ? timeout_q : timeout_q + TO_W'(1);
      good_inc_w     = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
   end

   // Deframing FSM and lock tracking; everything advances on the bit strobe.
   always_comb begin
      state_d       = state_q;
      window_d      = window_q;
      data_d        = data_q;
      parity_d      = parity_q;
      guard_d       = guard_q;
      cnt_d         = cnt_q;
      good_d        = good_q;
      timeout_d     = timeout_q;
      dout_d        = dout_q;
      data_valid_d  = 1'b0;
      frame_error_d = 1'b0;
      locked_d      = locked_q;

      if (bit_strobe_w) begin
         case (state_q)
            ST_HUNT: begin
               window_d = window_shift_w;
               if (window_shift_w == SYNC_WORD) begin
                  state_d   = ST_PAYLOAD;
                  cnt_d     = '0;
                  timeout_d = '0;
               end else begin
                  timeout_d = timeout_inc_w;
                  if (timeout_inc_w == TO_MAX) begin
                     locked_d = 1'b0;
                     good_d   = '0;
                  end
               end
            end
            ST_PAYLOAD: begin
               data_d = {data_q[DATA_BITS-2:0], bit_val_w};
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_DATA) begin
                  cnt_d   = '0;
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               parity_d = bit_val_w;
               state_d  = ST_GUARD;
            end
            ST_GUARD: begin
               guard_d = guard_shift_w;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_GUARD) begin
                  cnt_d    = '0;
                  state_d  = ST_HUNT;
                  window_d = '0;
                  if (frame_ok_w) begin
                     data_valid_d = 1'b1;
                     dout_d       = data_q;
                     good_d       = good_inc_w;
                     if (good_inc_w == GOOD_MAX) begin
                        locked_d = 1'b1;
                     end
                  end else begin
                     frame_error_d = 1'b1;
                     good_d        = '0;
                     locked_d      = 1'b0;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_HUNT;
         window_q      <= '0;
         data_q        <= '0;
         parity_q      <= 1'b0;
         guard_q       <= '0;
         cnt_q         <= '0;
         good_q        <= '0;
         timeout_q     <= '0;
         dout_q        <= '0;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         window_q      <= window_d;
         data_q        <= data_d;
         parity_q      <= parity_d;
         guard_q       <= guard_d;
         cnt_q         <= cnt_d;
         good_q        <= good_d;
         timeout_q     <= timeout_d;
         dout_q        <= dout_d;
         data_valid_q  <= data_valid_d;
         frame_error_q <= frame_error_d;
         locked_q      <= locked_d;
      end
   end

   assign dout        = dout_q;
   assign data_valid  = data_valid_q;
   assign frame_error = frame_error_q;
   assign locked      = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_disassembly.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_disassembly
// Description : Self-checking bench for frame_disassembly. The driver builds
//               serial frames and pushes the expected outcome of each into a
//               scoreboard; a monitor pops and compares on every output pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_disassembly;

   localparam int OS    = 8;
   localparam int LOCKF = 3;
   localparam int TO    = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic [19:0] dout;
   logic        data_valid;
   logic        frame_error;
   logic        locked;

   always #5 clk = ~clk;

   frame_disassembly #(
      .OVERSAMPLE   (OS),
      .LOCK_FRAMES  (LOCKF),
      .TIMEOUT_BITS (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .dout        (dout),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .locked      (locked)
   );

   typedef struct packed {
      logic        good;
      logic [19:0] dout;
      logic        locked;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model of the link as seen from outside.
   int          m_good   = 0;
   logic        m_locked = 1'b0;
   logic [19:0] m_dout   = '0;
   int          m_gap    = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp_v);
      end
   endtask

   task automatic model_reset();
      m_good   = 0;
      m_locked = 1'b0;
      m_dout   = '0;
      m_gap    = 0;
   endtask

   // Line held at 0 for n bit periods; a long enough gap is a timeout.
   task automatic idle(input int n);
      din = 1'b0;
      repeat (n * OS) @(negedge clk);
      m_gap += n;
      if (m_gap >= TO) begin
         m_locked = 1'b0;
         m_good   = 0;
      end
   endtask

   task automatic send_frame(input logic [19:0] data, input logic pflip,
                             input logic [2:0] guard, input logic jitter);
      logic [31:0] fr;
      int          off[33];
      exp_t        e;
      logic        ok;
      fr = {8'hE8, data, (^data) ^ pflip, guard};
      // The 7 leading sync bits are unmatched hunt strobes too.
      if (m_gap + 7 >= TO) begin
         m_locked = 1'b0;
         m_good   = 0;
      end
      m_gap = 0;
      ok = !pflip && (guard == 3'b000);
      if (ok) begin
         m_good = (m_good + 1 > LOCKF) ? LOCKF : m_good + 1;
         if (m_good >= LOCKF) m_locked = 1'b1;
         m_dout = data;
      end else begin
         m_good   = 0;
         m_locked = 1'b0;
      end
      e.good   = ok;
      e.dout   = m_dout;
      e.locked = m_locked;
      off[0]  = 0;
      off[32] = 0;
      for (int i = 1; i < 32; i++) off[i] = jitter ? int'($urandom_range(2)) - 1 : 0;
      for (int i = 0; i < 32; i++) begin
         if (i == 31) sb.push_back(e);
         din = fr[31-i];
         repeat (OS + off[i+1] - off[i]) @(negedge clk);
      end
   endtask

   // Sync plus the first npay payload bits, then nothing: an abandoned frame.
   task automatic send_partial(input logic [19:0] data, input int npay);
      logic [31:0] fr;
      fr = {8'hE8, data, ^data, 3'b000};
      m_gap = 0;
      for (int i = 0; i < 8 + npay; i++) begin
         din = fr[31-i];
         repeat (OS) @(negedge clk);
      end
   endtask

   // Monitor: every output pulse consumes one expected outcome.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (data_valid && frame_error) begin
            checks++;
            errors++;
            $display("FAIL pulse_exclusive data_valid=%0b frame_error=%0b required one-hot", data_valid, frame_error);
         end else if (data_valid || frame_error) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse data_valid=%0b frame_error=%0b required none", data_valid, frame_error);
            end else begin
               e = sb.pop_front();
               check("pulse_is_valid", {31'd0, data_valid}, {31'd0, e.good});
               check("dout_at_pulse", {12'd0, dout}, {12'd0, e.dout});
               check("locked_at_pulse", {31'd0, locked}, {31'd0, e.locked});
            end
         end
      end
   end

   initial begin
      int          kind;
      logic [2:0]  g;
      int          wait_cyc;
      rst = 1'b1;
      din = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("reset_dout", {12'd0, dout}, {12'd0, m_dout});
      check("reset_data_valid", {31'd0, data_valid}, 32'd0);
      check("reset_frame_error", {31'd0, frame_error}, 32'd0);
      check("reset_locked", {31'd0, locked}, {31'd0, m_locked});

      // Clean frame, then the same frame with bad parity.
      idle(4);
      send_frame(20'hABCDE, 1'b0, 3'b000, 1'b0);
      idle(2);
      send_frame(20'hABCDE, 1'b1, 3'b000, 1'b0);
      idle(2);

      // Back-to-back good frames reach lock; a bad guard drops it.
      send_frame(20'h00001, 1'b0, 3'b000, 1'b0);
      send_frame(20'h80000, 1'b0, 3'b000, 1'b0);
      send_frame(20'hFFFFF, 1'b0, 3'b000, 1'b0);
      send_frame(20'h12345, 1'b0, 3'b010, 1'b0);
      idle(2);

      // Payload containing the sync pattern, with edge jitter.
      send_frame(20'hE8E8E, 1'b0, 3'b000, 1'b1);
      idle(3);

      // Randomised traffic.
      for (int n = 0; n < 24; n++) begin
         kind = int'($urandom_range(3));
         g    = (kind == 3) ? 3'($urandom_range(1, 7)) : 3'b000;
         send_frame(20'($urandom), (kind == 2), g, 1'($urandom_range(1)));
         idle(int'($urandom_range(3)));
      end

      // Lock, then idle long enough to time out, then resume.
      send_frame(20'h13579, 1'b0, 3'b000, 1'b0);
      send_frame(20'h2468A, 1'b0, 3'b000, 1'b0);
      send_frame(20'h0F0F0, 1'b0, 3'b000, 1'b0);
      idle(250);
      check("locked_before_timeout", {31'd0, locked}, {31'd0, m_locked});
      idle(12);
      check("locked_after_timeout", {31'd0, locked}, {31'd0, m_locked});
      idle(38);
      send_frame(20'h5A5A5, 1'b0, 3'b000, 1'b0);
      idle(2);

      // Reset in the middle of a payload.
      send_frame(20'h11111, 1'b0, 3'b000, 1'b0);
      send_partial(20'hC3C3C, 10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("midrst_dout", {12'd0, dout}, {12'd0, m_dout});
      check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
      check("midrst_frame_error", {31'd0, frame_error}, 32'd0);
      check("midrst_locked", {31'd0, locked}, {31'd0, m_locked});
      idle(4);
      send_frame(20'h7BCD1, 1'b0, 3'b000, 1'b0);
      idle(4);

      // Drain outstanding expectations, bounded.
      wait_cyc = 0;
      while (sb.size() != 0 && wait_cyc < 200) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("scoreboard_drained", sb.size(), 32'd0);
      check("final_dout", {12'd0, dout}, {12'd0, m_dout});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
